// File: rtl/act_pkg.sv
// Shared activation-path definitions: default sample geometry and the
// signed sample type used by the interpolator, the LUT and the layer.
package act_pkg;

    localparam int ACT_DATA_W = 8;
    localparam int ACT_ADDR_W = 4;
    localparam int ACT_FRAC_W = ACT_DATA_W - ACT_ADDR_W;

    typedef logic signed [ACT_DATA_W-1:0] act_sample_t;

endpackage

// File: rtl/interp_mult_add.sv
// Combinational linear interpolation between two adjacent LUT entries.
// Ports: base_i/next_i (signed entries), frac_i (unsigned fraction),
//        result_o = base + ((next - base) * frac) >>> FRAC_W.
module interp_mult_add #(
    parameter int DATA_W = 8,
    parameter int FRAC_W = 4
) (
    input  logic signed [DATA_W-1:0] base_i,
    input  logic signed [DATA_W-1:0] next_i,
    input  logic        [FRAC_W-1:0] frac_i,
    output logic signed [DATA_W-1:0] result_o
);

    localparam int PW = DATA_W + FRAC_W + 2;

    logic signed [DATA_W:0] diff;
    logic signed [PW-1:0]   diff_w;
    logic signed [PW-1:0]   frac_w;
    logic signed [PW-1:0]   prod;
    logic signed [PW-1:0]   shr;
    logic signed [PW-1:0]   sum;
    logic                   unused_hi;

    always_comb begin
        diff   = {next_i[DATA_W-1], next_i} - {base_i[DATA_W-1], base_i};
        diff_w = {{(PW-DATA_W-1){diff[DATA_W]}}, diff};
        // Fraction is unsigned: zero-extend so the product keeps diff's sign.
        frac_w = {{(PW-FRAC_W){1'b0}}, frac_i};
        prod   = diff_w * frac_w;
        // Arithmetic shift floors toward negative infinity.
        shr    = prod >>> FRAC_W;
        sum    = shr + {{(PW-DATA_W){base_i[DATA_W-1]}}, base_i};
        // The result always lies between base and next, so it fits DATA_W.
        result_o = sum[DATA_W-1:0];
    end

    assign unused_hi = ^sum[PW-1:DATA_W];

endmodule

// File: rtl/act_lut_interp.sv
// Three-stage LUT interpolating activation: S1 din, S2 LUT pair + frac,
// S3 dout. Ports: din valid/ready in, lut_address/lut_base/lut_next to the
// external LUT, dout valid/ready out. Single global advance stalls all.
module act_lut_interp
    import act_pkg::*;
#(
    parameter int DATA_W = ACT_DATA_W,
    parameter int ADDR_W = ACT_ADDR_W,
    parameter int FRAC_W = DATA_W - ADDR_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     din_valid,
    output logic                     din_ready,
    input  logic signed [DATA_W-1:0] din,
    output logic        [ADDR_W-1:0] lut_address,
    input  logic signed [DATA_W-1:0] lut_base,
    input  logic signed [DATA_W-1:0] lut_next,
    output logic                     dout_valid,
    input  logic                     dout_ready,
    output logic signed [DATA_W-1:0] dout
);

    logic                     advance;

    logic                     s1_valid_q, s1_valid_d;
    logic signed [DATA_W-1:0] s1_din_q, s1_din_d;

    logic                     s2_valid_q, s2_valid_d;
    logic signed [DATA_W-1:0] s2_base_q, s2_base_d;
    logic signed [DATA_W-1:0] s2_next_q, s2_next_d;
    logic        [FRAC_W-1:0] s2_frac_q, s2_frac_d;

    logic                     s3_valid_q, s3_valid_d;
    logic signed [DATA_W-1:0] dout_q, dout_d;

    logic signed [DATA_W-1:0] interp_res;

    interp_mult_add #(
        .DATA_W (DATA_W),
        .FRAC_W (FRAC_W)
    ) u_interp (
        .base_i   (s2_base_q),
        .next_i   (s2_next_q),
        .frac_i   (s2_frac_q),
        .result_o (interp_res)
    );

    assign advance     = !s3_valid_q || dout_ready;
    assign din_ready   = advance && !rst;
    assign lut_address = s1_din_q[DATA_W-1:FRAC_W];
    assign dout_valid  = s3_valid_q;
    assign dout        = dout_q;

    always_comb begin
        s1_valid_d = s1_valid_q;
        s1_din_d   = s1_din_q;
        s2_valid_d = s2_valid_q;
        s2_base_d  = s2_base_q;
        s2_next_d  = s2_next_q;
        s2_frac_d  = s2_frac_q;
        s3_valid_d = s3_valid_q;
        dout_d     = dout_q;
        if (advance) begin
            // Valids always shift; data only moves behind a valid bit,
            // so bubbles leave the data registers untouched.
            s1_valid_d = din_valid;
            if (din_valid) begin
                s1_din_d = din;
            end
            s2_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                s2_base_d = lut_base;
                s2_next_d = lut_next;
                s2_frac_d = s1_din_q[FRAC_W-1:0];
            end
            s3_valid_d = s2_valid_q;
            if (s2_valid_q) begin
                dout_d = interp_res;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_din_q   <= '0;
            s2_valid_q <= 1'b0;
            s2_base_q  <= '0;
            s2_next_q  <= '0;
            s2_frac_q  <= '0;
            s3_valid_q <= 1'b0;
            dout_q     <= '0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_din_q   <= s1_din_d;
            s2_valid_q <= s2_valid_d;
            s2_base_q  <= s2_base_d;
            s2_next_q  <= s2_next_d;
            s2_frac_q  <= s2_frac_d;
            s3_valid_q <= s3_valid_d;
            dout_q     <= dout_d;
        end
    end

endmodule

// File: tb/tb_act_lut_interp.sv
// Bench for act_lut_interp: behavioural LUT + interpolation model with a
// per-cycle compare process, plus directed vectors with literal results.
module tb_act_lut_interp;
    import act_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        din_valid;
    logic        din_ready;
    act_sample_t din;
    logic [3:0]  lut_address;
    act_sample_t lut_base;
    act_sample_t lut_next;
    logic        dout_valid;
    logic        dout_ready;
    act_sample_t dout;

    int checks = 0;
    int errors = 0;
    int lut [16];
    int exp_q [$];
    int got [$];

    always #5 clk = ~clk;

    act_lut_interp dut (
        .clk         (clk),
        .rst         (rst),
        .din_valid   (din_valid),
        .din_ready   (din_ready),
        .din         (din),
        .lut_address (lut_address),
        .lut_base    (lut_base),
        .lut_next    (lut_next),
        .dout_valid  (dout_valid),
        .dout_ready  (dout_ready),
        .dout        (dout)
    );

    function automatic int lnext(input int a);
        if (a == 7) return lut[7];
        if (a == 15) return lut[0];
        return lut[a+1];
    endfunction

    always_comb begin
        lut_base = 8'(lut[lut_address]);
        lut_next = 8'(lnext(int'(lut_address)));
    end

    function automatic int floor_div16(input int a);
        int q;
        q = a / 16;
        if ((a % 16 != 0) && (a < 0)) q = q - 1;
        return q;
    endfunction

    function automatic int model(input logic [7:0] d);
        int a, f, b, n;
        a = int'(d[7:4]);
        f = int'(d[3:0]);
        b = lut[a];
        n = lnext(a);
        return b + floor_div16((n - b) * f);
    endfunction

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    // Scoreboard update on the edge, then compare 1 time unit later.
    always @(posedge clk) begin
        logic       r, st;
        int         hd, ha;
        r  = rst;
        st = dout_valid && !dout_ready;
        hd = int'(dout);
        ha = int'(lut_address);
        if (r) begin
            exp_q.delete();
        end else begin
            if (dout_valid && dout_ready) begin
                got.push_back(int'(dout));
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            if (din_valid && din_ready) exp_q.push_back(model(din));
        end
        #1;
        chk("din_ready_rule", int'(din_ready),
            int'((!dout_valid || dout_ready) && !rst));
        if (r) begin
            chk("rst_dout_valid", int'(dout_valid), 0);
            chk("rst_dout", int'(dout), 0);
            chk("rst_lut_address", int'(lut_address), 0);
        end else if (st) begin
            chk("stall_dout", int'(dout), hd);
            chk("stall_valid", int'(dout_valid), 1);
            chk("stall_addr", int'(lut_address), ha);
        end
        if (dout_valid) begin
            chk("output_expected", int'(exp_q.size() > 0), 1);
            if (exp_q.size() > 0) chk("model_dout", int'(dout), exp_q[0]);
        end
    end

    task automatic burst(input int n, input int ds[4], input int es[4],
                         input string nm);
        for (int j = 0; j < n + 3; j++) begin
            @(negedge clk);
            if (j >= 3) begin
                chk({nm, "_valid"}, int'(dout_valid), 1);
                chk(nm, int'(dout), es[j-3]);
            end
            if (j < n) begin
                din_valid = 1'b1;
                din = 8'(ds[j]);
            end else begin
                din_valid = 1'b0;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 16; i++) lut[i] = (i < 8) ? 16 * i : 0;
        rst = 1'b1;
        din_valid = 1'b0;
        din = '0;
        dout_ready = 1'b1;
        repeat (3) @(negedge clk);
        chk("reset_din_ready", int'(din_ready), 0);
        chk("reset_addr", int'(lut_address), 0);
        chk("reset_dout_valid", int'(dout_valid), 0);
        rst = 1'b0;

        // Single sample, latency 2 edges after accept.
        din_valid = 1'b1;
        din = 8'h25;
        @(negedge clk);
        din_valid = 1'b0;
        chk("addr_0x25", int'(lut_address), 2);
        chk("lat_k0", int'(dout_valid), 0);
        @(negedge clk);
        chk("lat_k1", int'(dout_valid), 0);
        @(negedge clk);
        chk("lat_k2", int'(dout_valid), 1);
        chk("dout_0x25", int'(dout), 37);
        repeat (2) @(negedge clk);

        burst(2, '{8'h7F, 8'hF8, 0, 0}, '{112, 0, 0, 0}, "top_seg");
        burst(4, '{8'h00, 8'h08, 8'h18, 8'h3C}, '{0, 8, 24, 60}, "b2b");
        repeat (2) @(negedge clk);

        // Stall with three samples in flight.
        got.delete();
        dout_ready = 1'b0;
        din_valid = 1'b1;
        din = 8'h11;
        @(negedge clk);
        din = 8'h22;
        @(negedge clk);
        din = 8'h33;
        @(negedge clk);
        din = 8'h44;
        for (int i = 0; i < 3; i++) begin
            chk("stall_din_ready", int'(din_ready), 0);
            chk("stall_head", int'(dout), 17);
            @(negedge clk);
        end
        dout_ready = 1'b1;
        @(negedge clk);
        din_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("stall_count", got.size(), 4);
        if (got.size() == 4) begin
            chk("stall_o0", got[0], 17);
            chk("stall_o1", got[1], 34);
            chk("stall_o2", got[2], 51);
            chk("stall_o3", got[3], 68);
        end

        // Extreme adjacent entries, full fraction sweep both directions.
        lut[5] = -128;
        lut[6] = 127;
        lut[7] = -128;
        got.delete();
        for (int i = 0; i < 32; i++) begin
            din_valid = 1'b1;
            din = 8'(8'h50 + i);
            @(negedge clk);
        end
        din_valid = 1'b0;
        repeat (5) @(negedge clk);
        chk("sweep_count", got.size(), 32);
        if (got.size() == 32) begin
            chk("sweep_up0", got[0], -128);
            chk("sweep_up1", got[1], -113);
            chk("sweep_up15", got[15], 111);
            chk("sweep_dn0", got[16], 127);
            chk("sweep_dn1", got[17], 111);
            chk("sweep_dn15", got[31], -113);
            for (int i = 0; i < 15; i++) begin
                chk("mono_up", int'(got[i+1] >= got[i]), 1);
                chk("mono_dn", int'(got[i+17] <= got[i+16]), 1);
            end
        end
        for (int i = 0; i < 16; i++) lut[i] = (i < 8) ? 16 * i : 0;

        // Reset with two samples in flight.
        din_valid = 1'b1;
        din = 8'h25;
        @(negedge clk);
        din = 8'h37;
        @(negedge clk);
        din_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_valid", int'(dout_valid), 0);
        rst = 1'b0;
        din_valid = 1'b1;
        din = 8'h08;
        @(negedge clk);
        din_valid = 1'b0;
        chk("post_rst_k0", int'(dout_valid), 0);
        @(negedge clk);
        chk("post_rst_k1", int'(dout_valid), 0);
        @(negedge clk);
        chk("post_rst_k2", int'(dout_valid), 1);
        chk("post_rst_dout", int'(dout), 8);
        repeat (4) @(negedge clk);
        chk("drain", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule

// File: doc/act_lut_interp.md
ACT_LUT_INTERP -- requirements
Module: act_lut_interp

Interface
REQ-001 Parameter DATA_W, default 8: signed sample width of din, dout and the LUT entries.
REQ-002 Parameter ADDR_W, default 4: LUT address width, with 2**ADDR_W entries.
REQ-003 Parameter FRAC_W, default DATA_W-ADDR_W: interpolation fraction width.
REQ-004 clk  in  1: single clock; all state changes on the rising edge.
REQ-005 rst  in  1: reset, synchronous and active-high.
REQ-006 din_valid  in  1: input sample valid.
REQ-007 din_ready  out  1: block can accept a sample.
REQ-008 din  in  DATA_W signed: pre-activation sample from the layer accumulator.
REQ-009 lut_address  out  ADDR_W: address driven to the activation LUT.
REQ-010 lut_base  in  DATA_W signed: LUT entry at lut_address, returned combinationally.
REQ-011 lut_next  in  DATA_W signed: successor LUT entry for lut_address, returned combinationally.
REQ-012 dout_valid  out  1: result valid.
REQ-013 dout_ready  in  1: downstream accepts the result.
REQ-014 dout  out  DATA_W signed: interpolated activation output.

Function
REQ-015 A sample SHALL be accepted on a rising edge where din_valid and din_ready are both 1.
REQ-016 A result SHALL be consumed on a rising edge where dout_valid and dout_ready are both 1.
REQ-017 Pipeline SHALL be 3 registered stages: S1 (din), S2 (base, next, frac), S3 (dout); each stage holds its own valid bit.
REQ-018 advance = !dout_valid | dout_ready; all stages SHALL load only when advance=1 and SHALL hold otherwise; din_ready = advance & !rst.
REQ-019 Latency: a sample accepted at edge k SHALL appear on dout with dout_valid=1 after edge k+2, given no stall; throughput SHALL be 1 sample per cycle.
REQ-020 lut_address SHALL equal S1 din[DATA_W-1:FRAC_W], driven from the S1 register; S1 frac = din[FRAC_W-1:0], treated as unsigned.
REQ-021 S2 SHALL capture lut_base, lut_next and frac in the same edge.
REQ-022 S3 output: dout = base + ((next - base) * frac) >>> FRAC_W.
REQ-023 Arithmetic width rules: diff is DATA_W+1 bits signed; product is DATA_W+FRAC_W+2 bits signed; the shift is arithmetic, truncating toward negative infinity.
REQ-024 Result SHALL lie within [min(base,next), max(base,next)]; no saturation logic SHALL be present.
REQ-025 Boundary, top segment: the block SHALL add no special case for address 0111 or address 1111; the LUT supplies lut_next (saturating and wrapping respectively), and the block uses it verbatim.
REQ-026 frac=0 SHALL yield dout=base exactly.
REQ-027 Stall: during dout_valid=1 and dout_ready=0, dout, dout_valid and all stage registers SHALL stay constant.
REQ-028 Bubbles (din_valid=0) SHALL propagate as valid=0 without altering data registers.

Reset
REQ-029 While rst=1 at an edge, all stage valids and dout_valid SHALL clear to 0, dout and the S1 register SHALL clear to 0 (so lut_address=0), and din_ready SHALL be 0.
REQ-030 Reset asserted mid-operation SHALL discard all in-flight samples with no partial output; the first accept SHALL be possible on the first edge after rst falls.

Structure
REQ-031 Shared package act_pkg SHALL hold the DATA_W/ADDR_W/FRAC_W defaults and the signed sample typedef, for reuse by the LUT and the layer.
REQ-032 One sub-module, interp_mult_add, SHALL be combinational, hold the REQ-022/REQ-023 arithmetic, and feed S3.
REQ-033 The LUT SHALL remain external; the block SHALL contain no table storage.

Verification (bench LUT model: entries 0..7 = 16*i, entries 8..15 = 0; next of entry 7 = 112, next of entry 15 = entry 0)
REQ-034 din=0x25 -> lut_address=2, dout=37 after edge k+2.
REQ-035 din=0x7F -> dout=112 (saturating top entry); din=0xF8 -> dout=0 (wrap entry 15 -> entry 0).
REQ-036 Back-to-back 0x00, 0x08, 0x18, 0x3C with dout_ready=1 -> dout 0, 8, 24, 60 on consecutive cycles.
REQ-037 dout_ready=0 for 3 cycles with 3 samples in flight -> din_ready=0 and dout held; on release, no sample is lost or duplicated.
REQ-038 Bench LUT entries -128 and 127 adjacent, frac 0..15 sweep -> monotonic dout, bit-exact to REQ-022, with no overflow.
REQ-039 rst pulsed with 2 samples in flight -> dout_valid=0 on the next cycle, with no stale output after rst falls.
